milestone1_divider: RTL and testbench
=====================================

# milestone1_divider

Sequential signed 32-bit integer divider for the milestone 1 datapath, the inverse operation to the shared multiplier. It accepts a dividend/divisor pair on a single-cycle start strobe and computes quotient and remainder with a restoring shift-subtract algorithm, one quotient bit per clock. It reports completion with a one-cycle done pulse. It serves the normalisation and scaling steps that the multiply-only datapath cannot express, and costs one subtractor in place of a combinational divider.

## Interface
- No parameters; width is fixed at 32 bits.
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs.
- start  input  1  request strobe; sampled only in IDLE.
- dividend  input  32  signed two's-complement; sampled on the accepting edge.
- divisor  input  32  signed two's-complement; sampled on the accepting edge.
- busy  output  1  high while in ITER or FINISH.
- done  output  1  one-cycle pulse when quotient/remainder/div_by_zero are updated.
- quotient  output  32  signed result, truncated toward zero.
- remainder  output  32  signed; sign follows the dividend; |remainder| < |divisor|.
- div_by_zero  output  1  set with done when the divisor was 0.

## Operation
- States: IDLE, ITER, FINISH.
- IDLE, start=1, accepting edge:
  - Latch sign_q = dividend[31]^divisor[31] and sign_r = dividend[31].
  - Load the 33-bit unsigned magnitudes |dividend| and |divisor|, clear the partial remainder, set count=0.
  - Flag zero if divisor==0. Go to ITER.
- ITER, each edge:
  - Shift {partial remainder, magnitude-quotient} left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder (33-bit). If the result is non-negative, keep it and set the new quotient LSB to 1; otherwise restore and set it to 0.
  - count increments; after the 32nd iteration (count==31 on that edge) go to FINISH.
- FINISH, one edge:
  - quotient = sign_q ? -mag_q : mag_q and remainder = sign_r ? -mag_r : mag_r, both truncated to 32 bits.
  - div_by_zero = zero flag. done=1 for this one cycle. Go to IDLE.
- Divide by zero: the block runs the full iteration count (constant latency). FINISH forces quotient=0, remainder=dividend, div_by_zero=1.
- Overflow: 0x80000000 / 0xFFFFFFFF produces quotient=0x80000000 (wrapped), remainder=0, div_by_zero=0. No separate flag.
- Output hold: quotient, remainder and div_by_zero hold their last values until the next FINISH. div_by_zero is rewritten on every completion.
- start in ITER or FINISH is ignored; there is no queueing.
- start in the cycle done is high: the block is already in IDLE, so the request is accepted.
- Operands are captured only on the accepting edge; later input changes have no effect.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE, count=0.
- Reset is asynchronous and takes effect immediately, including mid-operation. An aborted operation never produces done, and the outputs read 0.
- Latency: if edge E0 accepts start, the ITER updates occur on E1..E32 and FINISH on E33. done and the new results are visible after E33 for one cycle.
- Back-to-back throughput is one result per 34 cycles, with start reasserted in the done cycle.
- busy is 1 from after E0 through E33 inclusive, and 0 in the cycle done is high.
- done is never high for two consecutive cycles.

## Test plan
- Reset, then dividend=100, divisor=7 -> done exactly 33 clocks after the accepting edge; quotient=14, remainder=2, div_by_zero=0.
- Sign cases:
  - -100/7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2).
  - 100/-7 -> -14, 2.
  - -100/-7 -> 14, -2.
- 7/0 -> after 33 clocks quotient=0, remainder=7, div_by_zero=1. A following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- Boundary operands:
  - 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - 0x7FFFFFFF/1 -> 0x7FFFFFFF, 0.
  - 5/9 -> 0, 5.
- Start 20/3 at E0, then pulse start with 50/5 at E10 -> the second request is ignored. A single done arrives after E33 with 6, 2, and busy stays 1 throughout.
- Assert Reset asynchronously between edges during iteration 10 -> busy and all outputs go to 0 immediately, and no done pulse follows. A new start after release completes normally.

Source files
------------

// File: rtl/milestone1_divider.sv
// milestone1_divider
// Sequential signed 32-bit divider using restoring shift-subtract, one quotient
// bit per clock. Quotient truncates toward zero. The remainder takes the sign of
// the dividend. The latency is fixed at 33 clocks after the accepting edge.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_start        request strobe, sampled only while idle
//   i_dividend     signed dividend, captured on the accepting edge
//   i_divisor      signed divisor, captured on the accepting edge
//   o_busy         high while iterating or finishing
//   o_done         one-cycle pulse when results are updated
//   o_quotient     signed quotient
//   o_remainder    signed remainder
//   o_div_by_zero  set with done when the divisor was zero
module milestone1_divider (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder,
  output logic        o_div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ITER   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic        r_sign_q;
  logic        r_sign_r;
  logic        r_zero;
  logic [32:0] r_rem;      // partial remainder magnitude
  logic [31:0] r_quo;      // dividend magnitude shifting out, quotient shifting in
  logic [32:0] r_dvs;      // divisor magnitude
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;
  logic        r_div_by_zero;

  logic [32:0] w_shift;
  logic [33:0] w_diff;

  // Trial subtraction on the shifted partial remainder; w_diff[33] set means negative.
  assign w_shift = {r_rem[31:0], r_quo[31]};
  assign w_diff  = {1'b0, w_shift} - {1'b0, r_dvs};

  // Control and datapath state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_count       <= 5'd0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_zero        <= 1'b0;
      r_rem         <= 33'd0;
      r_quo         <= 32'd0;
      r_dvs         <= 33'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= 32'd0;
      r_remainder   <= 32'd0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_sign_q <= i_dividend[31] ^ i_divisor[31];
            r_sign_r <= i_dividend[31];
            r_zero   <= (i_divisor == 32'd0);
            r_rem    <= 33'd0;
            // 0 - 0x80000000 wraps to 0x80000000, its correct unsigned magnitude
            r_quo    <= i_dividend[31] ? (32'd0 - i_dividend) : i_dividend;
            r_dvs    <= {1'b0, (i_divisor[31] ? (32'd0 - i_divisor) : i_divisor)};
            r_count  <= 5'd0;
            r_busy   <= 1'b1;
            r_state  <= S_ITER;
          end
        end
        S_ITER: begin
          r_rem   <= w_diff[33] ? w_shift : w_diff[32:0];
          r_quo   <= {r_quo[30:0], ~w_diff[33]};
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          // With a zero divisor every trial succeeds, so the remainder register
          // ends up holding |dividend| and re-signing it restores the dividend.
          r_quotient    <= r_zero ? 32'd0 : (r_sign_q ? (32'd0 - r_quo) : r_quo);
          r_remainder   <= 32'(r_sign_r ? (33'd0 - r_rem) : r_rem);
          r_div_by_zero <= r_zero;
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_milestone1_divider.sv
// Self-checking bench for milestone1_divider: directed sign/boundary cases,
// ignored start, async abort, and random operands against an arithmetic model.
module tb_milestone1_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int unsigned n_vec;
  int unsigned n_err;
  logic [31:0] last_q;
  logic [31:0] last_r;
  logic        last_z;

  milestone1_divider dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: signed division via 64-bit arithmetic, results wrapped to 32 bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = 32'd0;
      r = a;
      z = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
    end
  endfunction

  // One full operation. If poke > 0, a second start (50/5) is driven across edge poke+1.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int poke);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
    int          n;
    logic        busy_bad;
    model(a, b, eq, er, ez);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    chk({tag, "_done_e0"}, 32'(done), 32'd0);
    chk({tag, "_hold_q"}, quotient, last_q);
    n = 0;
    busy_bad = 1'b0;
    while (!done && n < 40) begin
      if (n == poke) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && busy !== 1'b1) busy_bad = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'd33);
    chk({tag, "_busy_iter"}, 32'(busy_bad), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_z"}, 32'(div_by_zero), 32'(ez));
    last_q = eq;
    last_r = er;
    last_z = ez;
  endtask

  initial begin
    int cnt;
    logic [31:0] a;
    logic [31:0] b;
    n_vec    = 0;
    n_err    = 0;
    last_q   = 32'd0;
    last_r   = 32'd0;
    last_z   = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_z", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases; the model also yields the values listed in the plan.
    do_op("p100_7", 32'd100, 32'd7, -1);
    chk("lit_q_14", quotient, 32'd14);
    chk("lit_r_2", remainder, 32'd2);
    do_op("m100_7", 32'hFFFF_FF9C, 32'd7, -1);
    chk("lit_q_m14", quotient, 32'hFFFF_FFF2);
    chk("lit_r_m2", remainder, 32'hFFFF_FFFE);
    do_op("p100_m7", 32'd100, 32'hFFFF_FFF9, -1);
    do_op("m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1);
    do_op("div0", 32'd7, 32'd0, -1);
    chk("lit_div0_z", 32'(div_by_zero), 32'd1);
    do_op("after0", 32'd9, 32'd3, -1);
    do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("lit_ovf_q", quotient, 32'h8000_0000);
    do_op("max_1", 32'h7FFF_FFFF, 32'd1, -1);
    do_op("small", 32'd5, 32'd9, -1);
    do_op("neg0", 32'h8000_0000, 32'd0, -1);
    do_op("ignored", 32'd20, 32'd3, 9);
    chk("lit_ign_q", quotient, 32'd6);
    chk("lit_ign_r", remainder, 32'd2);

    // Async abort during iteration, after a non-zero result.
    do_op("pre_abort", 32'd100, 32'd7, -1);
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    chk("abort_z", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_q = 32'd0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    do_op("post_abort", 32'd9, 32'd3, -1);

    // Random operands with a bias toward small, zero and extreme divisors.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'd0 - 32'($urandom_range(1, 20));
        3: b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      do_op("rand", a, b, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
